// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the counter family.
//   DIR_UP / DIR_DOWN    : values of the dir input.
//   MODE_WRAP / MODE_SAT : values of the sat input.
//   clamp_to_max()       : limits a value to a terminal count. Operands are
//                          carried at CNT_MAX_W bits so one function serves
//                          every counter width up to that size.
// -----------------------------------------------------------------------------
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Widest counter the shared helper supports.
  localparam int unsigned CNT_MAX_W = 64;

  function automatic logic [CNT_MAX_W-1:0] clamp_to_max(
    input logic [CNT_MAX_W-1:0] value,
    input logic [CNT_MAX_W-1:0] max
  );
    return (value > max) ? max : value;
  endfunction

endpackage : counter_pkg

// File: rtl/mode_counter_next.sv
// -----------------------------------------------------------------------------
// mode_counter_next
// Combinational step logic for mode_counter: the count that one enabled step
// produces, and whether that step crosses a boundary.
//   count        in  current count
//   dir          in  1 = up, 0 = down
//   sat          in  1 = saturate at boundary, 0 = wrap modulo MAX_VAL+1
//   next_count   out count after one enabled step
//   boundary_hit out step was taken at MAX_VAL (up) or 0 (down)
// -----------------------------------------------------------------------------
module mode_counter_next
  import counter_pkg::*;
#(
  parameter int unsigned       WIDTH   = 32,
  parameter logic [WIDTH-1:0]  MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic [WIDTH-1:0] count,
  input  logic             dir,
  input  logic             sat,
  output logic [WIDTH-1:0] next_count,
  output logic             boundary_hit
);

  logic at_top;
  logic at_bottom;

  // Boundaries are compared explicitly against MAX_VAL and 0, so a modulus
  // smaller than 2^WIDTH wraps correctly and +1 / -1 never overflow.
  assign at_top    = (count == MAX_VAL);
  assign at_bottom = (count == '0);

  // NOTE: every output gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    next_count   = count;
    boundary_hit = 1'b0;
    if (dir == DIR_UP) begin
      if (at_top) begin
        boundary_hit = 1'b1;
        next_count   = (sat == MODE_SAT) ? count : '0;
      end else begin
        next_count = count + WIDTH'(1);
      end
    end else begin
      if (at_bottom) begin
        boundary_hit = 1'b1;
        next_count   = (sat == MODE_SAT) ? count : MAX_VAL;
      end else begin
        next_count = count - WIDTH'(1);
      end
    end
  end

endmodule : mode_counter_next

// File: rtl/mode_counter.sv
// -----------------------------------------------------------------------------
// mode_counter
// Up/down counter with programmable terminal count, runtime wrap/saturate,
// parallel load (clamped to MAX_VAL) and clear-to-preset.
// Priority per edge: clr > load > en; otherwise the count holds.
//   clk, rst_n      clock, asynchronous active-low reset
//   en, dir, sat    step enable, direction (1 = up), saturate mode
//   clr             synchronous clear to CLR_VAL
//   load, load_val  synchronous parallel load
//   count           registered count
//   at_max, at_min  combinational count == MAX_VAL / count == 0
//   ovf             registered pulse the cycle after a boundary step
// Build option MODE_COUNTER_STICKY_OVF_EN adds:
//   ovf_ack    in  clears ovf_sticky (a coincident ovf event wins)
//   ovf_sticky out latched ovf, also cleared by clr
// -----------------------------------------------------------------------------
module mode_counter
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] CLR_VAL = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             sat,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef MODE_COUNTER_STICKY_OVF_EN
  input  logic             ovf_ack,
  output logic             ovf_sticky,
`endif
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             ovf
);

  // Parameter sanity, caught at elaboration.
  if (WIDTH < 1 || WIDTH > CNT_MAX_W) begin : g_bad_width
    $error("mode_counter: WIDTH must be 1..%0d", CNT_MAX_W);
  end
  if (MAX_VAL == '0) begin : g_bad_max
    $error("mode_counter: MAX_VAL must be at least 1");
  end
  if (CLR_VAL > MAX_VAL) begin : g_bad_clr
    $error("mode_counter: CLR_VAL must not exceed MAX_VAL");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] step_count;
  logic             step_boundary;

  mode_counter_next #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_next (
    .count        (count_q),
    .dir          (dir),
    .sat          (sat),
    .next_count   (step_count),
    .boundary_hit (step_boundary)
  );

  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    if (clr) begin
      count_d = CLR_VAL;
    end else if (load) begin
      count_d = WIDTH'(clamp_to_max(CNT_MAX_W'(load_val), CNT_MAX_W'(MAX_VAL)));
    end else if (en) begin
      count_d = step_count;
      ovf_d   = step_boundary;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count  = count_q;
  assign ovf    = ovf_q;
  assign at_max = (count_q == MAX_VAL);
  assign at_min = (count_q == '0);

`ifdef MODE_COUNTER_STICKY_OVF_EN
  logic sticky_q, sticky_d;

  // A new ovf event takes precedence over a same-cycle acknowledge.
  // clr forces ovf_d low, so clr always clears the sticky bit.
  always_comb begin
    sticky_d = ovf_d | (sticky_q & ~ovf_ack & ~clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign ovf_sticky = sticky_q;
`endif

endmodule : mode_counter

// File: tb/tb_mode_counter.sv
// -----------------------------------------------------------------------------
// tb_mode_counter
// Directed bench for mode_counter at WIDTH=4, MAX_VAL=9, CLR_VAL=1.
// Inputs change on the falling edge; outputs are compared 1 ns after the
// rising edge. Sticky-flag sequences are compiled in when
// MODE_COUNTER_STICKY_OVF_EN is defined.
// -----------------------------------------------------------------------------
module tb_mode_counter;

  localparam int unsigned W = 4;
  localparam logic [W-1:0] MAXV = 4'd9;
  localparam logic [W-1:0] CLRV = 4'd1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en, dir, sat, clr, load, ovf_ack;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         at_max, at_min, ovf;
`ifdef MODE_COUNTER_STICKY_OVF_EN
  logic         ovf_sticky;
`endif

  int errors = 0;
  int checks = 0;

  mode_counter #(
    .WIDTH   (W),
    .MAX_VAL (MAXV),
    .CLR_VAL (CLRV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .dir        (dir),
    .sat        (sat),
    .clr        (clr),
    .load       (load),
    .load_val   (load_val),
`ifdef MODE_COUNTER_STICKY_OVF_EN
    .ovf_ack    (ovf_ack),
    .ovf_sticky (ovf_sticky),
`endif
    .count      (count),
    .at_max     (at_max),
    .at_min     (at_min),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  typedef struct {
    logic         clr;
    logic         load;
    logic         en;
    logic         dir;
    logic         sat;
    logic [W-1:0] load_val;
    logic [W-1:0] exp_count;
    logic         exp_ovf;
    logic         exp_at_max;
    logic         exp_at_min;
  } vec_t;

  // Drive controls at the falling edge, then wait for the rising edge.
  task automatic drive_step(input logic c, input logic l, input logic e,
                            input logic d, input logic s, input logic [W-1:0] lv,
                            input logic ack);
    @(negedge clk);
    clr = c; load = l; en = e; dir = d; sat = s; load_val = lv; ovf_ack = ack;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[17];

  initial begin
    //            clr  load en   dir  sat  lv     cnt   ovf  max  min
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  4'd1, 1'b0, 1'b0, 1'b0}; // clear
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd8,  4'd8, 1'b0, 1'b0, 1'b0}; // load 8
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  4'd9, 1'b0, 1'b1, 1'b0}; // up to max
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  4'd0, 1'b1, 1'b0, 1'b1}; // wrap up
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  4'd1, 1'b0, 1'b0, 1'b0}; // after wrap
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0,  4'd0, 1'b0, 1'b0, 1'b1}; // down to 0
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0,  4'd0, 1'b1, 1'b0, 1'b1}; // sat low
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0,  4'd0, 1'b1, 1'b0, 1'b1}; // sat again
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  4'd0, 1'b0, 1'b0, 1'b1}; // drop en
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd15, 4'd9, 1'b0, 1'b1, 1'b0}; // clamp load
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0,  4'd9, 1'b1, 1'b1, 1'b0}; // sat high
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd7,  4'd1, 1'b0, 1'b0, 1'b0}; // clr wins
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4'd0, 1'b0, 1'b0, 1'b1}; // down
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4'd9, 1'b1, 1'b1, 1'b0}; // wrap down
    vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd5,  4'd5, 1'b0, 1'b0, 1'b0}; // load over en
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  4'd5, 1'b0, 1'b0, 1'b0}; // hold
    vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  4'd6, 1'b0, 1'b0, 1'b0}; // up

    // Reset state.
    rst_n = 1'b0; en = 1'b0; dir = 1'b1; sat = 1'b0; clr = 1'b0;
    load = 1'b0; load_val = '0; ovf_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_count", 32'(count), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    check("reset_at_min", 32'(at_min), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 17; i++) begin
      drive_step(vecs[i].clr, vecs[i].load, vecs[i].en, vecs[i].dir,
                 vecs[i].sat, vecs[i].load_val, 1'b0);
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].exp_ovf));
      check($sformatf("vec%0d_at_max", i), 32'(at_max), 32'(vecs[i].exp_at_max));
      check($sformatf("vec%0d_at_min", i), 32'(at_min), 32'(vecs[i].exp_at_min));
    end

    // Async reset mid-count: count 7, en held high.
    drive_step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd6, 1'b0);
    drive_step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    check("pre_reset_count", 32'(count), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_count", 32'(count), 32'd0);
    @(posedge clk);
    #1;
    check("reset_held_count", 32'(count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_release_count", 32'(count), 32'd1);

    // Pending ovf is dropped by reset.
    drive_step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0);
    drive_step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    check("wrap_before_reset_ovf", 32'(ovf), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("reset_drops_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0;

`ifdef MODE_COUNTER_STICKY_OVF_EN
    drive_step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    check("sticky_after_clr", 32'(ovf_sticky), 32'd0);
    drive_step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0);
    drive_step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    check("sticky_set_on_wrap", 32'(ovf_sticky), 32'd1);
    for (int i = 0; i < 10; i++) begin
      drive_step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
      check($sformatf("sticky_hold%0d", i), 32'(ovf_sticky), 32'd1);
    end
    check("sticky_idle_ovf", 32'(ovf), 32'd0);
    drive_step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0);
    drive_step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
    check("sticky_set_beats_ack", 32'(ovf_sticky), 32'd1);
    drive_step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
    check("sticky_ack_clears", 32'(ovf_sticky), 32'd0);
    drive_step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    check("sticky_stays_clear", 32'(ovf_sticky), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mode_counter
